// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to the
// instruction RAM write port, holding the CPU in reset for the duration of the load.
// Optional feature: define IMEM_LOADER_CHKSUM_EN to add chk_i/sum_o and a word-sum check at DONE.
module imem_loader #(
  parameter int unsigned    AW   = 16,
  parameter logic [AW-1:0]  BASE = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
`ifdef IMEM_LOADER_CHKSUM_EN
  input  logic [31:0]   chk_i,
  output logic [31:0]   sum_o,
`endif
  output logic          byte_ready_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [31:0]   wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cpu_hold_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_t;

  // Number of words in the memory; a load may end exactly at the top, never past it.
  localparam logic [AW+1:0] MemWords = {2'b01, {AW{1'b0}}};

  state_t        state_q;
  logic [1:0]    byte_cnt_q;
  logic [AW:0]   word_cnt_q;
  logic [AW:0]   len_q;
  logic [31:0]   asm_q;
  logic [AW-1:0] idx_q;

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [31:0]   chk_q;
  logic [31:0]   sum_next;
  assign sum_next = sum_o + wdata_o;
`endif

  logic [AW+1:0] end_addr;
  logic          overflow;
  logic          handshake;
  logic [AW:0]   word_cnt_inc;

  assign end_addr     = {2'b00, BASE} + {1'b0, len_i};
  assign overflow     = end_addr > MemWords;
  assign handshake    = byte_valid_i & byte_ready_o;
  assign word_cnt_inc = word_cnt_q + 1'b1;

  // Load FSM; all outputs are registered and updated on the transition into each state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      idx_q        <= '0;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cpu_hold_o   <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q        <= '0;
      sum_o        <= '0;
`endif
    end else begin
      we_o   <= 1'b0;
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i == '0) begin
              state_q    <= StDone;
              done_o     <= 1'b1;
              busy_o     <= 1'b1;
              cpu_hold_o <= 1'b1;
              word_cnt_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
              // Empty program sums to zero.
              chk_q      <= chk_i;
              sum_o      <= '0;
              err_o      <= (chk_i != 32'd0);
`else
              err_o      <= 1'b0;
`endif
            end else if (overflow) begin
              err_o <= 1'b1;
            end else begin
              state_q      <= StCollect;
              len_q        <= len_i;
              idx_q        <= BASE;
              waddr_o      <= BASE;
              word_cnt_q   <= '0;
              byte_cnt_q   <= '0;
              asm_q        <= '0;
              err_o        <= 1'b0;
              byte_ready_o <= 1'b1;
              busy_o       <= 1'b1;
              cpu_hold_o   <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
              chk_q        <= chk_i;
              sum_o        <= '0;
`endif
            end
          end
        end
        StCollect: begin
          if (handshake) begin
            unique case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= byte_i;
              2'd1: asm_q[15:8]  <= byte_i;
              2'd2: asm_q[23:16] <= byte_i;
              2'd3: asm_q[31:24] <= byte_i;
              default: asm_q     <= asm_q;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // The fourth byte bypasses asm_q so the write happens on the very next cycle.
              state_q      <= StWrite;
              byte_ready_o <= 1'b0;
              we_o         <= 1'b1;
              wdata_o      <= {byte_i, asm_q[23:0]};
              waddr_o      <= idx_q;
            end
          end
        end
        StWrite: begin
          idx_q      <= idx_q + 1'b1;
          word_cnt_q <= word_cnt_inc;
`ifdef IMEM_LOADER_CHKSUM_EN
          sum_o      <= sum_next;
`endif
          if (word_cnt_inc == len_q) begin
            state_q <= StDone;
            done_o  <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
            if (sum_next != chk_q) err_o <= 1'b1;
`endif
          end else begin
            state_q      <= StCollect;
            byte_cnt_q   <= '0;
            byte_ready_o <= 1'b1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          busy_o     <= 1'b0;
          cpu_hold_o <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default AW=16/BASE=0 plus a small AW=4/BASE=14
// instance for the overflow boundary). Define IMEM_LOADER_CHKSUM_EN to also test the checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] len = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, we, busy, done, err, cpu_hold;
  logic [15:0] waddr;
  logic [31:0] wdata;

  // Small instance for overflow checks.
  logic        start_s = 1'b0;
  logic [4:0]  len_s = '0;
  logic        byte_ready_s, we_s, busy_s, done_s, err_s, cpu_hold_s;
  logic [3:0]  waddr_s;
  logic [31:0] wdata_s;

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [31:0] chk = '0;
  logic [31:0] sum, sum_s;
`endif

  always #5 clk = ~clk;

  imem_loader #(.AW(16), .BASE(16'd0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .byte_i(byte_data), .byte_valid_i(byte_valid),
`ifdef IMEM_LOADER_CHKSUM_EN
    .chk_i(chk), .sum_o(sum),
`endif
    .byte_ready_o(byte_ready), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .cpu_hold_o(cpu_hold)
  );

  imem_loader #(.AW(4), .BASE(4'd14)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .len_i(len_s),
    .byte_i(byte_data), .byte_valid_i(1'b0),
`ifdef IMEM_LOADER_CHKSUM_EN
    .chk_i(32'd0), .sum_o(sum_s),
`endif
    .byte_ready_o(byte_ready_s), .we_o(we_s), .waddr_o(waddr_s), .wdata_o(wdata_s),
    .busy_o(busy_s), .done_o(done_s), .err_o(err_s), .cpu_hold_o(cpu_hold_s)
  );

  int n_checks = 0;
  int n_err = 0;

  // Write/done monitor sampled on the falling edge.
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          rdy_viol = 0;
  int          we_s_cnt = 0;
  logic [31:0] wr_data [0:63];
  logic [15:0] wr_addr [0:63];
  int          wr_cyc  [0:63];
  logic        wr_hold [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (we && wr_cnt < 64) begin
        wr_data[wr_cnt] <= wdata;
        wr_addr[wr_cnt] <= waddr;
        wr_cyc[wr_cnt]  <= cyc;
        wr_hold[wr_cnt] <= cpu_hold;
        wr_cnt          <= wr_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (we && byte_ready) rdy_viol <= rdy_viol + 1;
      if (we_s) we_s_cnt <= we_s_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic start_load(input logic [16:0] l, input logic [31:0] c);
    start = 1'b1;
    len   = l;
`ifdef IMEM_LOADER_CHKSUM_EN
    chk   = c;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge inside the DONE cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_rdy"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_waddr"}, {16'd0, waddr}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
`ifdef IMEM_LOADER_CHKSUM_EN
    check({tag, "_sum"}, sum, 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    logic [31:0] bp_words [0:2];
    int gaps [0:11];
    bp_words = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A};
    gaps     = '{0, 2, 0, 1, 0, 0, 3, 0, 1, 0, 2, 0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic load of two words
    base = wr_cnt;
    start_load(17'd2, 32'd0);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_hold", {31'd0, cpu_hold}, 32'd1);
    check("basic_rdy", {31'd0, byte_ready}, 32'd1);
    send_word(32'h00000013);
    send_word(32'h00100093);
    wait_done();
    check("basic_hold_done", {31'd0, cpu_hold}, 32'd1);
    check("basic_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("basic_done_pulse", {31'd0, done}, 32'd0);
    check("basic_hold_after", {31'd0, cpu_hold}, 32'd0);
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    check("basic_wr_cnt", wr_cnt - base, 32'd2);
    check("basic_addr0", {16'd0, wr_addr[base]}, 32'd0);
    check("basic_data0", wr_data[base], 32'h00000013);
    check("basic_addr1", {16'd0, wr_addr[base+1]}, 32'd1);
    check("basic_data1", wr_data[base+1], 32'h00100093);
    check("basic_rate", wr_cyc[base+1] - wr_cyc[base], 32'd5);
    check("basic_done_lat", done_cyc - wr_cyc[base+1], 32'd1);
    check("basic_hold_wr0", {31'd0, wr_hold[base]}, 32'd1);
    check("basic_hold_wr1", {31'd0, wr_hold[base+1]}, 32'd1);
    check("basic_we_idle", {31'd0, we}, 32'd0);
    check("basic_waddr_hold", {16'd0, waddr}, 32'd1);
    check("basic_wdata_hold", wdata, 32'h00100093);

    // Zero length
    base  = wr_cnt;
    dbase = done_cnt;
    start_load(17'd0, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_err", {31'd0, err}, 32'd0);
    check("zero_we", {31'd0, we}, 32'd0);
    @(negedge clk);
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    check("zero_idle", {31'd0, busy}, 32'd0);
    check("zero_no_write", wr_cnt - base, 32'd0);
    check("zero_done_cnt", done_cnt - dbase, 32'd1);

    // Overflow on AW=4, BASE=14: 14+3 > 16 rejected, 14+2 == 16 accepted
    start_s = 1'b1;
    len_s   = 5'd3;
    @(negedge clk);
    start_s = 1'b0;
    check("ovf_err", {31'd0, err_s}, 32'd1);
    check("ovf_busy", {31'd0, busy_s}, 32'd0);
    check("ovf_hold", {31'd0, cpu_hold_s}, 32'd0);
    @(negedge clk);
    check("ovf_err_sticky", {31'd0, err_s}, 32'd1);
    start_s = 1'b1;
    len_s   = 5'd2;
    @(negedge clk);
    start_s = 1'b0;
    check("ovf_clear_err", {31'd0, err_s}, 32'd0);
    check("ovf_edge_busy", {31'd0, busy_s}, 32'd1);
    check("ovf_edge_waddr", {28'd0, waddr_s}, 32'd14);
    check("ovf_no_write", we_s_cnt, 32'd0);

    // Backpressure and gaps, three words
    base = wr_cnt;
    start_load(17'd3, 32'd0);
    for (int i = 0; i < 12; i++) begin
      send_byte(bp_words[i/4][8*(i%4) +: 8]);
      for (int g = 0; g < gaps[i]; g++) @(negedge clk);
    end
    wait_done();
    @(negedge clk);
    check("bp_wr_cnt", wr_cnt - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_addr%0d", i), {16'd0, wr_addr[base+i]}, i);
      check($sformatf("bp_data%0d", i), wr_data[base+i], bp_words[i]);
    end
    check("bp_rdy_in_write", rdy_viol, 32'd0);

    // Stray start during COLLECT, then reset mid-word
    base  = wr_cnt;
    dbase = done_cnt;
    start_load(17'd2, 32'd0);
    send_byte(8'h44);
    send_byte(8'h33);
    start = 1'b1;
    len   = 17'd1;
    @(negedge clk);
    start = 1'b0;
    check("stray_busy", {31'd0, busy}, 32'd1);
    check("stray_err", {31'd0, err}, 32'd0);
    check("stray_rdy", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("stray_wr_cnt", wr_cnt - base, 32'd1);
    check("stray_data", wr_data[base], 32'h11223344);
    check("stray_no_done", done_cnt - dbase, 32'd0);
    check("stray_still_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    start_load(17'd1, 32'd0);
    send_word(32'hCAFEF00D);
    wait_done();
    @(negedge clk);
    check("fresh_wr_cnt", wr_cnt - base, 32'd1);
    check("fresh_addr", {16'd0, wr_addr[base]}, 32'd0);
    check("fresh_data", wr_data[base], 32'hCAFEF00D);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Checksum match and mismatch
    start_load(17'd2, 32'h001000A6);
    check("chk_sum_clear", sum, 32'd0);
    send_word(32'h00000013);
    send_word(32'h00100093);
    wait_done();
    check("chk_ok_err", {31'd0, err}, 32'd0);
    check("chk_ok_sum", sum, 32'h001000A6);
    @(negedge clk);
    start_load(17'd2, 32'h001000A7);
    send_word(32'h00000013);
    send_word(32'h00100093);
    wait_done();
    check("chk_bad_err", {31'd0, err}, 32'd1);
    check("chk_bad_sum", sum, 32'h001000A6);
    @(negedge clk);
    check("chk_bad_sticky", {31'd0, err}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream and writes it into the instruction RAM write port, word by word.
- Sits between a byte source (UART receiver or debug bridge) and the instruction memory that the fetch stage reads by word index.
- Holds the CPU in reset while loading, so fetch never sees a partially written program.

Parameters:
- AW, 16, word-address width; matches the fetch word index, i.e. byte address bits [17:2].
- BASE, 0, first word index written; width AW.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle request to begin a load; sampled only in IDLE.
- len_i  in  AW+1  number of 32-bit words to load; sampled with start_i.
- byte_i  in  8  incoming program byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader accepts byte_i this cycle.
- we_o  out  1  instruction memory write enable, one-cycle pulse per word.
- waddr_o  out  AW  word index for the write.
- wdata_o  out  32  assembled instruction word.
- busy_o  out  1  a load is in progress.
- done_o  out  1  one-cycle pulse when the load completes.
- err_o  out  1  sticky error flag; cleared by the next accepted start_i.
- cpu_hold_o  out  1  hold the CPU in reset while high.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte count 0; word count 0; assembly register 0.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start_i=1 with len_i>0 and BASE+len_i<=2^AW: latch len_i, set waddr to BASE, clear err_o, go to COLLECT.
  - start_i=1 with len_i=0: go directly to DONE; no write.
  - start_i=1 with BASE+len_i>2^AW: set err_o, stay in IDLE, no writes.
- COLLECT:
  - byte_ready_o=1.
  - Each handshake (byte_valid_i & byte_ready_o) stores the byte little-endian: byte k of a word goes to bits [8k+7:8k], k=0..3.
  - The 4th accepted byte moves to WRITE on the next edge.
- WRITE (exactly one cycle):
  - we_o=1, wdata_o=assembled word, waddr_o=current index, byte_ready_o=0.
  - Next edge: increment index and word count.
  - If the word count reaches len, go to DONE; else clear byte count and go to COLLECT.
- DONE: done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in COLLECT, WRITE and DONE.
- cpu_hold_o=1 from the cycle after start_i is accepted through the DONE cycle; it drops together with the return to IDLE.
- Latency: one write one cycle after the 4th byte handshake. Sustained rate is 1 word per 5 cycles with back-to-back valid bytes.
- Signals outside their states:
  - we_o is 0 outside WRITE.
  - wdata_o and waddr_o hold their last values outside WRITE.
- start_i while busy: ignored; does not restart and does not set err_o.
- byte_valid_i outside COLLECT: not consumed, because byte_ready_o=0; the source must hold the byte.
- Reset mid-load: immediate return to IDLE with all outputs 0. Partial words are discarded; memory contents already written remain.
- waddr_o never wraps, because the overflow check at start guarantees this.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- When defined:
  - An extra input chk_i[31:0] is sampled with start_i.
  - A running 32-bit modulo-2^32 sum of every written word is kept.
  - On entry to DONE, if sum != chk_i, set err_o.
  - sum_o[31:0] output shows the running sum; it is 0 at reset and cleared on an accepted start_i.
- When undefined: no chk_i or sum_o ports, and err_o is set only by the overflow condition.

Test Plan:
- Basic load: reset, start_i with len_i=2, bytes 13 00 00 00 93 00 10 00.
  - Expect we_o pulses writing 0x00000013 at index 0, then 0x00100093 at index 1.
  - Expect done_o one cycle after the second write; cpu_hold_o high throughout and low after DONE.
- Zero length: start_i with len_i=0.
  - Expect done_o pulse on the next cycle, no we_o, err_o=0.
- Overflow: AW=4, BASE=14, start_i with len_i=3.
  - Expect err_o=1, busy_o=0, no writes; a following valid start_i clears err_o.
- Backpressure and gaps: random idle cycles between bytes plus byte_valid_i held during WRITE.
  - Expect no byte lost or duplicated and byte_ready_o=0 in the WRITE cycle; 3 words arrive intact.
- Reset mid-word and stray start: assert rst_i after 2 bytes of word 1, and also pulse start_i during COLLECT.
  - Expect outputs return to 0 immediately, the second start is ignored, and a fresh load writes from BASE again.
- Checksum (with IMEM_LOADER_CHKSUM_EN): words 0x00000013 and 0x00100093 loaded.
  - With chk_i=0x001000A6: expect sum_o=0x001000A6 and err_o=0.
  - With chk_i=0x001000A7: expect err_o=1 at DONE.
